// File: rtl/pipearch_common.sv
// Definitions shared by the pipearch streaming stages: stream FSM encoding and
// the instruction register map.
package pipearch_common;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } t_stream_state;

   localparam int REG_LENGTH     = 4;
   localparam int REG_LOCAL_BASE = 5;

endpackage

// File: rtl/pipearch_skid_fifo.sv
// Skid FIFO with a registered output. A pop while empty and pushing forwards the
// incoming word straight to the output register, so an idle FIFO adds one cycle.
module pipearch_skid_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_empty,
   output logic                       o_full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_dout;
   logic             w_bypass;
   logic             w_write;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_bypass = i_pop && (r_count == '0);
   assign w_write  = i_push && !w_bypass;

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (i_pop) begin
            if (w_bypass) begin
               r_dout <= i_din;
            end else begin
               r_dout   <= r_mem[r_rd_ptr];
               r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
         end
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   assign o_dout  = r_dout;
   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));

   ovf_chk: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_push && !i_pop && (r_count == CW'(DEPTH))));
   unf_chk: assert property (@(posedge clk) disable iff (!reset_n)
      !(i_pop && !i_push && (r_count == '0)));

endmodule

// File: rtl/pipearch_local_stream.sv
// Streams a contiguous run of lines from local line memory to the writeback stage,
// issuing reads only while the skid FIFO can absorb every outstanding return.
module pipearch_local_stream
   import pipearch_common::*;
#(
   parameter int LINE_WIDTH = 512,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 2,
   parameter int SKID_DEPTH = 8,
   parameter int NUM_REGS   = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         op_start,
   output logic                         op_done,
   input  logic [NUM_REGS-1:0][31:0]    regs,
   output logic                         mem_re,
   output logic [ADDR_WIDTH-1:0]        mem_raddr,
   input  logic [LINE_WIDTH-1:0]        mem_rdata,
   input  logic                         out_almostfull,
   output logic                         out_rvalid,
   output logic [LINE_WIDTH-1:0]        out_rdata
);

   localparam int FCW = $clog2(SKID_DEPTH + 1);
   localparam int CW  = FCW + 1;

   t_stream_state         r_state;
   logic [15:0]           r_len;
   logic [15:0]           r_issued;
   logic [15:0]           r_sent;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_mem_raddr;
   logic                  r_mem_re;
   logic                  r_out_rvalid;
   logic                  r_op_done;
   logic [RD_LATENCY-1:0] r_vld;

   logic [FCW-1:0]        w_fifo_count;
   logic                  w_fifo_empty;
   logic                  w_fifo_full;
   logic [CW-1:0]         w_pending;
   logic                  w_issue;
   logic                  w_last_issue;
   logic                  w_push;
   logic                  w_pop;
   logic [15:0]           w_start_len;
   logic                  w_unused_regs;

   assign w_start_len   = regs[REG_LENGTH][15:0];
   assign w_unused_regs = ^regs;

   // Reads in flight, counting the one on the bus this cycle and the one returning now.
   always_comb begin
      w_pending = CW'(r_mem_re);
      for (int i = 0; i < RD_LATENCY; i++) begin
         w_pending = w_pending + CW'(r_vld[i]);
      end
   end

   assign w_issue      = (r_state == ISSUE) && (r_issued != r_len) && !w_fifo_full &&
                         ((w_pending + CW'(w_fifo_count)) < CW'(SKID_DEPTH));
   assign w_last_issue = w_issue && ((r_issued + 16'd1) == r_len);
   assign w_push       = r_vld[RD_LATENCY-1];
   assign w_pop        = !out_almostfull && (!w_fifo_empty || w_push);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_issued     <= '0;
         r_sent       <= '0;
         r_base       <= '0;
         r_mem_raddr  <= '0;
         r_mem_re     <= 1'b0;
         r_out_rvalid <= 1'b0;
         r_op_done    <= 1'b0;
         r_vld        <= '0;
      end else begin
         r_mem_re     <= w_issue;
         r_vld        <= RD_LATENCY'({r_vld, r_mem_re});
         r_out_rvalid <= w_pop;
         r_op_done    <= (r_state == DONE);
         if (w_issue) begin
            r_mem_raddr <= r_base + ADDR_WIDTH'(r_issued);
            r_issued    <= r_issued + 16'd1;
         end
         if (w_pop) begin
            r_sent <= r_sent + 16'd1;
         end
         case (r_state)
            IDLE: begin
               if (op_start) begin
                  r_len    <= w_start_len;
                  r_base   <= regs[REG_LOCAL_BASE][ADDR_WIDTH-1:0];
                  r_issued <= '0;
                  r_sent   <= '0;
                  r_state  <= (w_start_len == 16'd0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (w_last_issue) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // True first in the cycle the final line is on out_rvalid.
               if (r_sent == r_len) begin
                  r_state <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   pipearch_skid_fifo #(
      .WIDTH (LINE_WIDTH),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_din   (mem_rdata),
      .i_pop   (w_pop),
      .o_dout  (out_rdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

   assign mem_re     = r_mem_re;
   assign mem_raddr  = r_mem_raddr;
   assign out_rvalid = r_out_rvalid;
   assign op_done    = r_op_done;

endmodule

// File: tb/tb_pipearch_local_stream.sv
// Bench for pipearch_local_stream: random line memory, expected stream built from
// base/length arithmetic, per-beat scoreboard plus latency and handshake checks.
module tb_pipearch_local_stream;

   localparam int LW  = 512;
   localparam int AW  = 10;
   localparam int LAT = 2;
   localparam int SD  = 8;
   localparam int NR  = 8;
   localparam int IDX_LEN  = 4;
   localparam int IDX_BASE = 5;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               op_start = 1'b0;
   logic               op_done;
   logic [NR-1:0][31:0] regs;
   logic               mem_re;
   logic [AW-1:0]      mem_raddr;
   logic [LW-1:0]      mem_rdata;
   logic               out_almostfull = 1'b0;
   logic               out_rvalid;
   logic [LW-1:0]      out_rdata;

   logic [LW-1:0]      mem_model [1<<AW];
   logic [AW-1:0]      rd_a1, rd_a2;
   logic [LW-1:0]      exp_q[$];
   int                 exp_addr_q[$];
   logic [LW-1:0]      last_data = '0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int re_cnt, beats, done_cnt, first_re, first_beat, last_beat, done_cyc;

   pipearch_local_stream #(
      .LINE_WIDTH (LW),
      .ADDR_WIDTH (AW),
      .RD_LATENCY (LAT),
      .SKID_DEPTH (SD),
      .NUM_REGS   (NR)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .op_start       (op_start),
      .op_done        (op_done),
      .regs           (regs),
      .mem_re         (mem_re),
      .mem_raddr      (mem_raddr),
      .mem_rdata      (mem_rdata),
      .out_almostfull (out_almostfull),
      .out_rvalid     (out_rvalid),
      .out_rdata      (out_rdata)
   );

   always #5 clk = ~clk;

   // Memory returns the line addressed LAT cycles earlier.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rd_a1 <= mem_raddr;
      rd_a2 <= rd_a1;
   end
   assign mem_rdata = mem_model[rd_a2];

   task automatic chk_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         last_data = '0;
      end else begin
         if (mem_re) begin
            if (re_cnt == 0) first_re = cyc;
            re_cnt++;
            chk_val("re_expected", LW'(exp_addr_q.size() != 0), LW'(1));
            if (exp_addr_q.size() != 0) chk_val("raddr", LW'(mem_raddr), LW'(exp_addr_q.pop_front()));
         end
         if (out_rvalid) begin
            if (beats == 0) first_beat = cyc;
            last_beat = cyc;
            beats++;
            chk_val("beat_expected", LW'(exp_q.size() != 0), LW'(1));
            if (exp_q.size() != 0) chk_val("rdata", out_rdata, exp_q.pop_front());
            last_data = out_rdata;
         end else begin
            chk_val("rdata_hold", out_rdata, last_data);
         end
         if (op_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // af_mode: 0 = never, 1 = high from start for af_cyc cycles, 2 = random.
   task automatic run_op(input int len, input int base, input int af_mode, input int af_cyc,
                         input int abort_at, input bit dbl);
      int t0;
      bit fin;
      fin = 1'b0;
      for (int r = 0; r < NR; r++) regs[r] = $urandom;
      regs[IDX_LEN]  = {16'($urandom), 16'(len)};
      regs[IDX_BASE] = ($urandom & ~32'h3FF) | 32'(base);
      exp_q.delete();
      exp_addr_q.delete();
      for (int i = 0; i < len; i++) begin
         exp_addr_q.push_back((base + i) % (1 << AW));
         exp_q.push_back(mem_model[(base + i) % (1 << AW)]);
      end
      re_cnt = 0; beats = 0; done_cnt = 0;
      first_re = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
      @(posedge clk); #1;
      op_start = 1'b1;
      t0 = cyc;
      out_almostfull = (af_mode == 1);
      for (int c = 0; c < 800 && !fin; c++) begin
         @(posedge clk); #1;
         op_start = dbl && (cyc == t0 + 3);
         if (dbl && cyc == t0 + 3) regs[IDX_LEN] = 32'd9;
         if (af_mode == 1 && cyc == t0 + af_cyc) begin
            chk_val("re_before_release", LW'(re_cnt <= SD), LW'(1));
            chk_val("beats_before_release", LW'(beats), LW'(0));
            out_almostfull = 1'b0;
         end else if (af_mode == 2) begin
            out_almostfull = ($urandom_range(0, 3) == 0);
         end
         if (abort_at > 0 && beats == abort_at) begin
            reset_n = 1'b0;
            #1;
            chk_val("rst_op_done", LW'(op_done), LW'(0));
            chk_val("rst_mem_re", LW'(mem_re), LW'(0));
            chk_val("rst_mem_raddr", LW'(mem_raddr), LW'(0));
            chk_val("rst_out_rvalid", LW'(out_rvalid), LW'(0));
            chk_val("rst_out_rdata", out_rdata, LW'(0));
            fin = 1'b1;
         end else if (done_cnt > 0) begin
            fin = 1'b1;
         end
      end
      op_start = 1'b0;
      out_almostfull = 1'b0;
      chk_val("op_finished", LW'(fin), LW'(1));
      if (abort_at > 0) begin
         repeat (3) @(posedge clk);
         #1 reset_n = 1'b1;
         $display("op len=%0d base=%03h aborted after %0d beats", len, base, beats);
      end else begin
         repeat (6) @(posedge clk);
         #1;
         chk_val("done_count", LW'(done_cnt), LW'(1));
         chk_val("beat_count", LW'(beats), LW'(len));
         chk_val("re_count", LW'(re_cnt), LW'(len));
         chk_val("leftover", LW'(exp_q.size()), LW'(0));
         if (af_mode == 0 && len > 0) begin
            chk_val("first_re_cyc", LW'(first_re - t0), LW'(2));
            chk_val("first_beat_cyc", LW'(first_beat - t0), LW'(3 + LAT));
            chk_val("last_beat_cyc", LW'(last_beat - first_beat), LW'(len - 1));
            chk_val("done_cyc", LW'(done_cyc - last_beat), LW'(2));
         end
         $display("op len=%0d base=%03h af=%0d beats=%0d re=%0d done_at=T+%0d",
                  len, base, af_mode, beats, re_cnt, done_cyc - t0);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++)
         for (int w = 0; w < LW / 32; w++)
            mem_model[i][w*32 +: 32] = $urandom;
      for (int r = 0; r < NR; r++) regs[r] = $urandom;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_val("init_op_done", LW'(op_done), LW'(0));
      chk_val("init_mem_re", LW'(mem_re), LW'(0));
      chk_val("init_mem_raddr", LW'(mem_raddr), LW'(0));
      chk_val("init_out_rvalid", LW'(out_rvalid), LW'(0));
      chk_val("init_out_rdata", out_rdata, LW'(0));
      reset_n = 1'b1;

      run_op(4, 'h010, 0, 0, 0, 1'b0);
      run_op(0, 'h123, 0, 0, 0, 1'b0);
      run_op(16, 'h200, 1, 20, 0, 1'b0);
      run_op(4, 'h3FE, 0, 0, 0, 1'b0);
      run_op(8, 'h050, 0, 0, 3, 1'b0);
      run_op(2, 'h060, 0, 0, 0, 1'b0);
      run_op(6, 'h070, 0, 0, 0, 1'b1);
      for (int k = 0; k < 6; k++)
         run_op(int'($urandom_range(1, 40)), int'($urandom_range(0, 1023)), 2, 0, 0, 1'b0);
      for (int k = 0; k < 3; k++)
         run_op(int'($urandom_range(1, 12)), int'($urandom_range(0, 1023)), 0, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
